// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide sequencer: a registered multiplier plus a 1-bit/cycle restoring
// divider, with a two-process controller that stalls EX and pulses done with the result.
module mdu_sequencer #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam logic [4:0] MUL_LAST = 5'(MUL_LATENCY - 1);
  localparam logic [4:0] DIV_LAST = 5'(XLEN - 1);

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     quot_q, quot_d;
  logic [XLEN-1:0]     dvsr_q, dvsr_d;
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand conditioning, evaluated on the request inputs at accept time
  logic                mul_a_signed, mul_b_signed;
  logic [2*XLEN-1:0]   mul_a_wide, mul_b_wide, mul_prod;
  logic                div_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_abs, b_abs;
  logic                div_by_zero, div_ovf;

  assign mul_a_signed = (funct3[1:0] != 2'b11);
  assign mul_b_signed = ~funct3[1];
  assign mul_a_wide   = {{XLEN{mul_a_signed & rs1_val[XLEN-1]}}, rs1_val};
  assign mul_b_wide   = {{XLEN{mul_b_signed & rs2_val[XLEN-1]}}, rs2_val};
  // Sign-extended operands make the low 2*XLEN bits of an unsigned product correct
  assign mul_prod     = mul_a_wide * mul_b_wide;

  assign div_signed  = ~funct3[0];
  assign a_neg       = div_signed & rs1_val[XLEN-1];
  assign b_neg       = div_signed & rs2_val[XLEN-1];
  assign a_abs       = a_neg ? (~rs1_val + 1'b1) : rs1_val;
  assign b_abs       = b_neg ? (~rs2_val + 1'b1) : rs2_val;
  assign div_by_zero = (rs2_val == '0);
  assign div_ovf     = div_signed && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);

  // One restoring-division step: the remainder never exceeds the divisor, so only the
  // shifted-out top bit needs the extra width for the comparison.
  logic [XLEN:0]   rem_shift;
  logic            rem_ge;
  logic [XLEN-1:0] rem_sub;
  logic [XLEN-1:0] quot_fix, rem_fix, mul_sel;

  assign rem_shift = {rem_q, quot_q[XLEN-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dvsr_q});
  assign rem_sub   = rem_shift[XLEN-1:0] - dvsr_q;
  assign quot_fix  = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
  assign rem_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
  assign mul_sel   = (op_q == 2'b00) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          op_d = funct3[1:0];
          if (!funct3[2]) begin
            prod_d  = mul_prod;
            cnt_d   = '0;
            state_d = S_MUL;
          end else if (div_by_zero) begin
            result_d = funct3[1] ? rs1_val : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = funct3[1] ? '0 : rs1_val;
            state_d  = S_DONE;
          end else begin
            quot_d     = a_abs;
            dvsr_d     = b_abs;
            rem_d      = '0;
            neg_quot_d = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            cnt_d      = '0;
            state_d    = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == MUL_LAST) begin
          result_d = mul_sel;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DIV: begin
        rem_d  = rem_ge ? rem_sub : rem_shift[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], rem_ge};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == DIV_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = op_q[1] ? rem_fix : quot_fix;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // An abort wins over everything, including a same-cycle request
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  assign busy   = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign stall  = (start && ((state_q == S_IDLE) || (state_q == S_DONE))) || busy;
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: hand-computed results and done latencies for
// multiply, divide, special cases, flush, mid-op reset and back-to-back requests.
module tb_mdu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  mdu_sequencer #(.XLEN(32), .MUL_LATENCY(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .flush   (flush),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Present one request, then count edges after the accept edge until done is seen.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_k);
    int k;
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b;
    #1 check({tag, " stall"}, {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    check({tag, " lat"}, k, exp_k);
    check({tag, " res"}, result, exp_res);
    @(negedge clk);
    check({tag, " pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; rs1_val = '0; rs2_val = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst stall", {31'd0, stall}, 32'd0);
    check("rst result", result, 32'd0);
    rst = 1'b0;

    do_op("MULHU ff*ff",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    do_op("MULH ff*ff",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
    do_op("MULHSU -1*ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    do_op("MUL -3*5",     3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 2);
    do_op("MULHU 2^31*4", 3'b011, 32'h8000_0000, 32'd4,         32'h0000_0002, 2);
    do_op("DIV -7/2",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    do_op("REM -7%2",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    do_op("DIV 7/-2",     3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    do_op("REM 7%-2",     3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33);
    do_op("DIVU 100/7",   3'b101, 32'd100,       32'd7,         32'd14,        33);
    do_op("REMU 100%7",   3'b111, 32'd100,       32'd7,         32'd2,         33);
    do_op("DIVU ff/1",    3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33);
    do_op("DIV min/2",    3'b100, 32'h8000_0000, 32'd2,         32'hC000_0000, 33);
    do_op("DIVU x/0",     3'b101, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 0);
    do_op("REMU x/0",     3'b111, 32'h1234_5678, 32'd0,         32'h1234_5678, 0);
    do_op("DIV ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op("REM ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);

    // Flush a divide at iteration 10; result must keep the previous value (0)
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; rs1_val = 32'd100; rs2_val = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("flush busy before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush result", result, 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("flush no done", dones, 0);
    do_op("MUL 3*5", 3'b000, 32'd3, 32'd5, 32'd15, 2);

    // Flush beats start in the same cycle
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; rs1_val = 32'd2; rs2_val = 32'd2;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush+start busy", {31'd0, busy}, 32'd0);

    // Back-to-back: start held through MUL (ignored) and into DONE (accepted)
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1_val = 32'd7; rs2_val = 32'd6;
    @(posedge clk);
    #1 rs1_val = 32'd9; rs2_val = 32'd9;
    @(negedge clk);
    check("b2b busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("b2b no early done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("b2b first done", {31'd0, done}, 32'd1);
    check("b2b first res", result, 32'd42);
    check("b2b stall in done", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b second busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("b2b second done", {31'd0, done}, 32'd1);
    check("b2b second res", result, 32'd81);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; rs1_val = 32'd50; rs2_val = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst busy", {31'd0, busy}, 32'd0);
    check("arst done", {31'd0, done}, 32'd0);
    check("arst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("arst no done", dones, 0);
    do_op("DIV 50/3", 3'b100, 32'd50, 32'd3, 32'd16, 33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
